// File: rtl/seg_display_pkg.sv
// Shared 7-segment display definitions.
//   SEG_BLANK     : all segments off (active-low).
//   HEX_SEG_TABLE : hex nibble -> {g,f,e,d,c,b,a}, active-low; entry 0 is the rightmost slice.
//   presc_width() : bit width needed for a 0..div-1 prescaler, never less than 1.
package seg_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic int presc_width(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex-to-7-segment decoder.
//   hex : 4-bit value to show
//   seg : {g,f,e,d,c,b,a}, active-low
module hex_to_seg
    import seg_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG_TABLE[hex];
    end

endmodule

// File: rtl/seg_refresh_scanner.sv
// Time-multiplexed scan controller for the 7-segment display.
// A prescaler divides clk down to one digit advance every DIV = CLK_HZ/REFRESH_HZ
// enabled cycles; each advance steps the 2-bit digit select and registers the
// matching segment pattern. Digit values and masks are captured into shadow
// registers once per frame, on the advance that returns the select to 0.
//   clk, reset          : clock, asynchronous active-high reset
//   enable              : 1 = scan runs, 0 = all state frozen
//   digit0..digit3      : hex value per digit (digit0 rightmost)
//   blank_mask, dp_mask : per-digit blank / decimal-point enables
//   twobitcounter       : digit select to the anode decoder
//   seg, dp             : active-low segment pattern and decimal point
//   digit_tick          : one-cycle pulse after every digit advance
module seg_refresh_scanner
    import seg_display_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int NUM_DIGITS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] blank_mask,
    input  logic [3:0] dp_mask,
    output logic [1:0] twobitcounter,
    output logic [6:0] seg,
    output logic       dp,
    output logic       digit_tick
);

    localparam int             DIV        = CLK_HZ / REFRESH_HZ;
    localparam int             PW         = presc_width(DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
    localparam logic [1:0]     CNT_LAST   = 2'(NUM_DIGITS - 1);

    logic [PW-1:0]   presc_q, presc_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            primed_q, primed_d;
    logic [3:0][3:0] dig_q, dig_d;
    logic [3:0]      blank_q, blank_d;
    logic [3:0]      dpm_q, dpm_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            tick_q, tick_d;

    logic            advance;
    logic            wrap;
    logic [3:0]      sel_hex;
    logic [6:0]      hex_seg;

    // Prescaler, digit select and frame latch.
    always_comb begin
        advance  = enable && (presc_q == PRESC_LAST);
        presc_d  = presc_q;
        cnt_d    = cnt_q;
        primed_d = primed_q;
        if (enable) begin
            presc_d = advance ? '0 : presc_q + 1'b1;
        end
        // The first advance after reset is treated as a frame wrap so the
        // display leaves its blank reset state with freshly latched values
        // starting at digit 0.
        if (advance) begin
            primed_d = 1'b1;
            if (!primed_q || cnt_q == CNT_LAST) begin
                cnt_d = 2'd0;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
        end
        wrap = advance && (cnt_d == 2'd0);
        // On the wrap edge the fresh inputs feed both the shadows and the
        // output decode, so a new frame shows without an extra cycle.
        dig_d   = wrap ? {digit3, digit2, digit1, digit0} : dig_q;
        blank_d = wrap ? blank_mask : blank_q;
        dpm_d   = wrap ? dp_mask    : dpm_q;
        sel_hex = dig_d[cnt_d];
    end

    hex_to_seg u_hex_to_seg (
        .hex (sel_hex),
        .seg (hex_seg)
    );

    // Output registers, updated only on an advance, from the new select value.
    always_comb begin
        seg_d  = seg_q;
        dp_d   = dp_q;
        tick_d = advance;
        if (advance) begin
            if (blank_d[cnt_d]) begin
                seg_d = SEG_BLANK;
                dp_d  = 1'b1;
            end else begin
                seg_d = hex_seg;
                dp_d  = ~dpm_d[cnt_d];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q  <= '0;
            cnt_q    <= 2'd0;
            primed_q <= 1'b0;
            dig_q    <= '0;
            blank_q  <= '0;
            dpm_q    <= '0;
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            dig_q    <= dig_d;
            blank_q  <= blank_d;
            dpm_q    <= dpm_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            tick_q   <= tick_d;
        end
    end

    assign twobitcounter = cnt_q;
    assign seg           = seg_q;
    assign dp            = dp_q;
    assign digit_tick    = tick_q;

endmodule
